cheshire_xilinx_rst_ctrl: RTL
=============================

# cheshire_xilinx_rst_ctrl

Board-level reset and boot-mode controller for the Cheshire Xilinx FPGA top. It debounces the board reset pushbutton and accepts a debug/software reset request. It sequences a parametrised number of active-low reset outputs with a minimum hold time and staggered release, and latches the boot-mode switches once per reset. It sits between the board pins and the SoC instance, replacing direct inversion of the button and the tied-off JTAG reset.

## Interface
- `NumRstOut`, 2: number of sequenced reset outputs (≥1).
- `BootModeWidth`, 2: boot-mode switch width (≥1).
- `SyncStages`, 2: synchronizer depth for button and switches (≥2).
- `DebounceCycles`, 50000: stable cycles required before debounced button level changes (≥1).
- `HoldCycles`, 1024: minimum cycles all resets stay asserted (≥1).
- `StageGapCycles`, 16: cycles between consecutive output releases (≥1).
- `BtnActiveHigh`, 1: button polarity; 1 means pressed reads high.
- `clk_i` in 1: the only clock.
- `rst_ni` in 1: asynchronous, active-low reset, i.e. power-on/MMCM-locked.
- `btn_rst_i` in 1: raw asynchronous pushbutton.
- `sw_rst_req_i` in 1: synchronous one-cycle reset request, e.g. debug ndmreset.
- `boot_mode_i` in BootModeWidth: raw asynchronous switches.
- `rst_no` out NumRstOut: active-low resets; bit 0 is released first.
- `boot_mode_o` out BootModeWidth: boot mode latched in SAMPLE.
- `rst_done_o` out 1: high only in RUN.
- `rst_cause_o` out 2: cause of last reset; 0=POR, 1=button, 2=software.
- `rst_count_o` out 8: saturating count of button and software resets since POR.

## Operation
- Button and switches pass through `SyncStages` flops, which reset to the inactive/0 state. The button is normalised to active-high using `BtnActiveHigh`.
- Debouncer: counter clears on any change of the synced level. The debounced level takes the synced value when the counter reaches `DebounceCycles-1`. A press event is the rising edge of the debounced level.
- FSM states and transitions:
  - ASSERT (reset state): all `rst_no`=0 and `rst_done_o`=0. Goes to HOLD after one cycle.
  - HOLD: hold counter increments. Goes to SAMPLE when the counter reaches `HoldCycles-1` and the debounced button is inactive. While the button is held, the counter saturates and the FSM stays in HOLD.
  - SAMPLE: one cycle. Latches synced `boot_mode_i` into `boot_mode_o`, releases `rst_no[0]`, and goes to RELEASE. If `NumRstOut`=1, it goes directly to RUN and sets `rst_done_o`.
  - RELEASE: releases `rst_no[k]` `StageGapCycles` after `rst_no[k-1]`. With the last release it goes to RUN and sets `rst_done_o`.
  - RUN: stays until a press event or `sw_rst_req_i`, then goes to ASSERT.
- A press event or `sw_rst_req_i` in HOLD clears the hold counter. In SAMPLE or RELEASE it forces ASSERT; all outputs re-assert on the next edge.
- On each accepted request, update `rst_cause_o`. If button and software requests arrive in the same cycle, the cause is button. `rst_count_o` increments by one per accepted request (simultaneous requests count once) and saturates at 255.
- `boot_mode_o`, `rst_cause_o` and `rst_count_o` are not cleared by button or software resets. Only `rst_ni` clears them.
- `rst_ni` low at any time asynchronously forces ASSERT and all reset values.

## Timing
- Reset values: `rst_no`=all 0, `boot_mode_o`=0, `rst_done_o`=0, `rst_cause_o`=0, `rst_count_o`=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Edge 1 is the first rising edge after `rst_ni` deasserts, with no button pressed:
  - ASSERT→HOLD at edge 1.
  - HOLD→SAMPLE at edge `HoldCycles`+1.
  - `rst_no[0]` rises and `boot_mode_o` updates at edge `HoldCycles`+2.
  - `rst_no[k]` rises at edge `HoldCycles`+2+k·`StageGapCycles`.
  - `rst_done_o` rises with the last `rst_no` bit.
- Button latency: press to ASSERT takes `SyncStages`+`DebounceCycles`+1 edges, ±1.
- `sw_rst_req_i` sampled in RUN: `rst_no`=0 and `rst_done_o`=0 on the next edge.

## Structure
- Package `cheshire_xilinx_rst_pkg`: FSM state enum (ASSERT, HOLD, SAMPLE, RELEASE, RUN) and cause enum (POR, BTN, SW).
- Counter widths are local `$clog2(max+1)` parameters. Parameter ranges are checked by elaboration-time assertions.
- Sub-module `cheshire_xilinx_debounce`: synchronizer plus debouncer, parametrised by `SyncStages` and `DebounceCycles`, outputting the debounced level and a press pulse.

## Test plan
Parameters for all scenarios: `NumRstOut`=3, `HoldCycles`=4, `StageGapCycles`=2, `DebounceCycles`=3, `SyncStages`=2.
- POR with `boot_mode_i`=2'b10 → `rst_no` bits rise at edges 6, 8, 10; `rst_done_o`=1 at edge 10; `boot_mode_o`=2'b10; `rst_cause_o`=0.
- In RUN, pulse `sw_rst_req_i` with switches at 2'b01 → `rst_no`=3'b000 next edge; release sequence repeats; `boot_mode_o`=2'b01, `rst_cause_o`=2, `rst_count_o`=1.
- 2-cycle button glitch in RUN → no reset. Then a 10-cycle press → reset with `rst_cause_o`=1 and `rst_count_o`=2. Hold the button 20 cycles → HOLD extends until release plus debounce.
- `sw_rst_req_i` when only `rst_no[0]` is released → all outputs return to 0 next edge; the full sequence restarts; the count increments.
- Simultaneous press event and `sw_rst_req_i` → `rst_cause_o`=1, count +1. 300 requests → `rst_count_o` saturates at 255.
- `rst_ni` pulsed low mid-RELEASE → all outputs return to reset values immediately and the POR sequence restarts.

Source files
------------

// File: rtl/cheshire_xilinx_rst_pkg.sv
// Shared types and helpers for the Cheshire Xilinx reset/boot-mode controller.
// State codes are plain constants so external checkers can bind to them directly.
package cheshire_xilinx_rst_pkg;

   typedef logic [2:0] rst_state_t;

   localparam rst_state_t ST_ASSERT  = 3'd0;
   localparam rst_state_t ST_HOLD    = 3'd1;
   localparam rst_state_t ST_SAMPLE  = 3'd2;
   localparam rst_state_t ST_RELEASE = 3'd3;
   localparam rst_state_t ST_RUN     = 3'd4;

   typedef enum logic [1:0] {
      CAUSE_POR = 2'd0,
      CAUSE_BTN = 2'd1,
      CAUSE_SW  = 2'd2
   } rst_cause_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cheshire_xilinx_debounce.sv
// Synchronizes an active-high button and debounces it; press_o pulses for one
// cycle on the rising edge of the debounced level.
module cheshire_xilinx_debounce #(
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 50000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

   logic [SyncStages-1:0] sync_q, sync_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  level_q, level_d;
   logic                  synced;

   always_comb begin
      sync_d  = {sync_q[SyncStages-2:0], btn_i};
      synced  = sync_q[SyncStages-1];
      last_d  = synced;
      cnt_d   = cnt_q;
      level_d = level_q;
      // Any change of the synced level restarts the stability window.
      if (synced != last_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_q == CntMax) begin
         level_d = last_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;
   assign press_o = level_d & ~level_q;

endmodule

// File: rtl/cheshire_xilinx_rst_ctrl.sv
// Board reset sequencer: debounced button / software requests, minimum hold,
// staggered active-low release and boot-mode latching once per reset.
module cheshire_xilinx_rst_ctrl
   import cheshire_xilinx_rst_pkg::*;
#(
   parameter int unsigned NumRstOut      = 2,
   parameter int unsigned BootModeWidth  = 2,
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 50000,
   parameter int unsigned HoldCycles     = 1024,
   parameter int unsigned StageGapCycles = 16,
   parameter bit          BtnActiveHigh  = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     btn_rst_i,
   // Single-cycle request: every cycle it is high while clocked counts as one request.
   input  logic                     sw_rst_req_i,
   input  logic [BootModeWidth-1:0] boot_mode_i,
   output logic [NumRstOut-1:0]     rst_no,
   output logic [BootModeWidth-1:0] boot_mode_o,
   output logic                     rst_done_o,
   output logic [1:0]               rst_cause_o,
   output logic [7:0]               rst_count_o
);

   if (NumRstOut == 0) begin : g_chk_num_rst
      $error("NumRstOut must be at least 1");
   end
   if (BootModeWidth == 0) begin : g_chk_boot_w
      $error("BootModeWidth must be at least 1");
   end
   if (SyncStages < 2) begin : g_chk_sync
      $error("SyncStages must be at least 2");
   end
   if (DebounceCycles == 0 || HoldCycles == 0 || StageGapCycles == 0) begin : g_chk_cycles
      $error("DebounceCycles, HoldCycles and StageGapCycles must be at least 1");
   end

   localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
   localparam int unsigned GapW  = (StageGapCycles > 1) ? $clog2(StageGapCycles) : 1;
   localparam int unsigned IdxW  = (NumRstOut > 1) ? $clog2(NumRstOut) : 1;

   localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles - 1);
   localparam logic [GapW-1:0]  GapMax  = GapW'(StageGapCycles - 1);
   localparam logic [IdxW-1:0]  IdxLast = IdxW'(NumRstOut - 1);

   logic btn_act, btn_level, press;

   // Inverting before the synchronizer lets its flops reset to "not pressed".
   assign btn_act = BtnActiveHigh ? btn_rst_i : ~btn_rst_i;

   cheshire_xilinx_debounce #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles)
   ) i_debounce (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .btn_i   (btn_act),
      .level_o (btn_level),
      .press_o (press)
   );

   logic [SyncStages-1:0][BootModeWidth-1:0] boot_sync_q;
   logic [BootModeWidth-1:0]                 boot_synced;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         boot_sync_q <= '0;
      end else begin
         boot_sync_q <= {boot_sync_q[SyncStages-2:0], boot_mode_i};
      end
   end

   assign boot_synced = boot_sync_q[SyncStages-1];

   rst_state_t               state_q, state_d;
   logic [HoldW-1:0]         hold_cnt_q, hold_cnt_d;
   logic [GapW-1:0]          gap_cnt_q, gap_cnt_d;
   logic [IdxW-1:0]          idx_q, idx_d;
   logic [NumRstOut-1:0]     rst_q, rst_d;
   logic                     done_q, done_d;
   logic [BootModeWidth-1:0] boot_q, boot_d;
   logic [1:0]               cause_q, cause_d;
   logic [7:0]               count_q, count_d;
   logic                     req;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      idx_d      = idx_q;
      rst_d      = rst_q;
      boot_d     = boot_q;
      cause_d    = cause_q;
      count_d    = count_q;
      req        = press | sw_rst_req_i;

      // The button wins the cause when both requests land in the same cycle.
      if (req) begin
         cause_d = press ? CAUSE_BTN : CAUSE_SW;
         count_d = sat_inc8(count_q);
      end

      case (state_q)
         ST_ASSERT: begin
            rst_d      = '0;
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            if (req) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HoldMax) begin
               if (!btn_level) begin
                  state_d = ST_SAMPLE;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
         end
         ST_SAMPLE: begin
            if (req) begin
               rst_d   = '0;
               state_d = ST_ASSERT;
            end else begin
               boot_d    = boot_synced;
               rst_d[0]  = 1'b1;
               gap_cnt_d = '0;
               idx_d     = IdxW'(1);
               state_d   = (NumRstOut == 1) ? ST_RUN : ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (req) begin
               rst_d   = '0;
               state_d = ST_ASSERT;
            end else if (gap_cnt_q == GapMax) begin
               gap_cnt_d = '0;
               for (int unsigned k = 1; k < NumRstOut; k++) begin
                  if (idx_q == IdxW'(k)) begin
                     rst_d[k] = 1'b1;
                  end
               end
               idx_d = idx_q + IdxW'(1);
               if (idx_q == IdxLast) begin
                  state_d = ST_RUN;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GapW'(1);
            end
         end
         ST_RUN: begin
            if (req) begin
               rst_d   = '0;
               state_d = ST_ASSERT;
            end
         end
         default: begin
            rst_d   = '0;
            state_d = ST_ASSERT;
         end
      endcase

      done_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_ASSERT;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         idx_q      <= '0;
         rst_q      <= '0;
         done_q     <= 1'b0;
         boot_q     <= '0;
         cause_q    <= CAUSE_POR;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         idx_q      <= idx_d;
         rst_q      <= rst_d;
         done_q     <= done_d;
         boot_q     <= boot_d;
         cause_q    <= cause_d;
         count_q    <= count_d;
      end
   end

   assign rst_no      = rst_q;
   assign rst_done_o  = done_q;
   assign boot_mode_o = boot_q;
   assign rst_cause_o = cause_q;
   assign rst_count_o = count_q;

endmodule
